// File: rtl/mulchan_wr_arbiter.sv
// Multi-channel write arbiter: shares one AXI write master between CH_NUM
// channel controllers with a round-robin grant that is held until the burst completes.
//
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   wr_req            - per-channel write request (bit i = channel i)
//   wr_addr, wr_len   - packed per-channel start address (30b) / burst length (8b)
//   wr_data           - packed per-channel FIFO read data (AXI_WIDTH each)
//   wr_grant          - one-hot grant, zero when idle
//   axi_wr_start      - one-cycle start pulse to the AXI write master
//   axi_wr_addr/len   - granted channel's address/length, latched at grant
//   axi_wr_data       - granted channel's wr_data, combinational mux
//   axi_wr_done       - burst complete pulse from the AXI write master
//
// Build option: define WR_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins); the default build is round-robin.

module mulchan_wr_arbiter #(
    parameter int CH_NUM    = 4,
    parameter int CH_IDX_W  = 2,
    parameter int AXI_WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [CH_NUM-1:0]           wr_req,
    input  logic [30*CH_NUM-1:0]        wr_addr,
    input  logic [8*CH_NUM-1:0]         wr_len,
    input  logic [AXI_WIDTH*CH_NUM-1:0] wr_data,
    output logic [CH_NUM-1:0]           wr_grant,
    output logic                        axi_wr_start,
    output logic [29:0]                 axi_wr_addr,
    output logic [7:0]                  axi_wr_len,
    output logic [AXI_WIDTH-1:0]        axi_wr_data,
    input  logic                        axi_wr_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_BUSY  = 2'd2
    } state_e;

    localparam logic [CH_IDX_W-1:0] LAST_RST = CH_IDX_W'(CH_NUM - 1);

    state_e              state_q, state_d;
    logic [CH_IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [CH_IDX_W-1:0] last_idx_q, last_idx_d;
    logic [29:0]         addr_q, addr_d;
    logic [7:0]          len_q, len_d;

    logic [CH_IDX_W-1:0] win_idx;
    logic                win_vld;
    logic [29:0]         win_addr;
    logic [7:0]          win_len;

    // Winner selection
`ifdef WR_ARB_FIXED_PRIO_EN
    // Scan high to low so the lowest requesting index is the last to write.
    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (wr_req[i]) begin
                win_vld = 1'b1;
                win_idx = CH_IDX_W'(i);
            end
        end
    end
`else
    // Offsets are scanned far to near so the channel closest after
    // last_idx is the last to write and therefore wins.
    logic [CH_IDX_W:0] cand;

    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        cand    = '0;
        for (int k = CH_NUM; k >= 1; k--) begin
            cand = {1'b0, last_idx_q} + (CH_IDX_W+1)'(k);
            if (cand >= (CH_IDX_W+1)'(CH_NUM)) begin
                cand = cand - (CH_IDX_W+1)'(CH_NUM);
            end
            if (wr_req[cand[CH_IDX_W-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[CH_IDX_W-1:0];
            end
        end
    end
`endif

    always_comb begin
        win_addr = '0;
        win_len  = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (CH_IDX_W'(i) == win_idx) begin
                win_addr = wr_addr[i*30 +: 30];
                win_len  = wr_len[i*8 +: 8];
            end
        end
    end

    // Next state
    always_comb begin
        state_d    = state_q;
        gnt_idx_d  = gnt_idx_q;
        last_idx_d = last_idx_q;
        addr_d     = addr_q;
        len_d      = len_q;
        unique case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    state_d   = S_GRANT;
                    gnt_idx_d = win_idx;
                    addr_d    = win_addr;
                    len_d     = win_len;
`ifndef WR_ARB_FIXED_PRIO_EN
                    last_idx_d = win_idx;
`endif
                end
            end
            // Done here is ignored: the master cannot finish in one cycle.
            S_GRANT: state_d = S_BUSY;
            S_BUSY: begin
                if (axi_wr_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        wr_grant     = '0;
        axi_wr_start = (state_q == S_GRANT);
        axi_wr_data  = '0;
        if (state_q != S_IDLE) begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (CH_IDX_W'(i) == gnt_idx_q) begin
                    wr_grant[i] = 1'b1;
                    axi_wr_data = wr_data[i*AXI_WIDTH +: AXI_WIDTH];
                end
            end
        end
    end

    assign axi_wr_addr = addr_q;
    assign axi_wr_len  = len_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            gnt_idx_q  <= '0;
            last_idx_q <= LAST_RST;
            addr_q     <= '0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            gnt_idx_q  <= gnt_idx_d;
            last_idx_q <= last_idx_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
        end
    end

endmodule
